// File: rtl/fde_cpu_core.sv
// fde_cpu_core: parametrised multicycle fetch-decode-execute CPU core
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset
//   i_stop       pause request, sampled only in FETCH
//   i_step       (FDE_STEP_EN only) single-step request while stopped
//   i_instr      combinational ROM data for address o_pc
//   o_pc         registered instruction address
//   o_write_en   one-cycle strobe marking a valid write-port transfer
//   o_write_add  write-port address, held between strobes
//   o_write_data write-port data, held between strobes
//   o_halted     core is in HALT until reset
// Optional single-step debug is enabled by defining FDE_STEP_EN.
module fde_cpu_core #(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 2,
    parameter int PC_W    = 4,
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 4 + 2 * REG_AW + DATA_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stop,
`ifdef FDE_STEP_EN
    input  logic               i_step,
`endif
    input  logic [INSTR_W-1:0] i_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_write_en,
    output logic [ADDR_W-1:0]  o_write_add,
    output logic [DATA_W-1:0]  o_write_data,
    output logic               o_halted
);
    localparam int NREG = 1 << REG_AW;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hB;

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   rf_q [NREG];
    logic [DATA_W-1:0]   rf_d [NREG];
    logic                z_q, z_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wadd_q, wadd_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   res;
    logic                go;

    logic [3:0]        op;
    logic [REG_AW-1:0] rd, rs;
    logic [DATA_W-1:0] imm;

    assign op  = ir_q[INSTR_W-1 -: 4];
    assign rd  = ir_q[INSTR_W-5 -: REG_AW];
    assign rs  = ir_q[INSTR_W-5-REG_AW -: REG_AW];
    assign imm = ir_q[DATA_W-1:0];

`ifdef FDE_STEP_EN
    // The lock stays set while i_step is held so one step request fetches
    // exactly one instruction; it clears once i_step is released.
    logic step_lock_q, step_lock_d;
    assign go          = !i_stop || (i_step && !step_lock_q);
    assign step_lock_d = !i_step ? 1'b0
                       : (state_q == S_FETCH && i_stop) ? 1'b1 : step_lock_q;
    always_ff @(posedge i_clk) begin
        if (i_reset) step_lock_q <= 1'b0;
        else         step_lock_q <= step_lock_d;
    end
`else
    assign go = !i_stop;
`endif

    always_comb begin
        res = '0;
        case (op)
            OP_LDI:  res = imm;
            OP_ADD:  res = a_q + b_q;
            OP_SUB:  res = a_q - b_q;
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_MOV:  res = b_q;
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        rf_d    = rf_q;
        z_d     = z_q;
        we_d    = 1'b0;
        wadd_d  = wadd_q;
        wdata_d = wdata_q;
        case (state_q)
            S_FETCH: begin
                if (go) begin
                    ir_d    = i_instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rd];
                b_d     = rf_q[rs];
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
                if (op >= OP_LDI && op <= OP_MOV) begin
                    rf_d[rd] = res;
                    z_d      = (res == '0);
                end
                if (op == OP_OUT) begin
                    we_d    = 1'b1;
                    wadd_d  = imm[ADDR_W-1:0];
                    wdata_d = b_q;
                end
                if (op == OP_JMP || (op == OP_JZ && z_q)) pc_d = imm[PC_W-1:0];
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rf_q    <= '{default: '0};
            z_q     <= 1'b0;
            we_q    <= 1'b0;
            wadd_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rf_q    <= rf_d;
            z_q     <= z_d;
            we_q    <= we_d;
            wadd_q  <= wadd_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_write_en   = we_q;
    assign o_write_add  = wadd_q;
    assign o_write_data = wdata_q;
    assign o_halted     = (state_q == S_HALT);
endmodule

// File: tb/tb_fde_cpu_core.sv
// tb_fde_cpu_core: directed scoreboard bench for fde_cpu_core
module tb_fde_cpu_core;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stop = 1'b0;
`ifdef FDE_STEP_EN
    logic        i_step = 1'b0;
`endif
    logic [15:0] i_instr;
    logic [3:0]  o_pc;
    logic        o_write_en;
    logic [3:0]  o_write_add;
    logic [7:0]  o_write_data;
    logic        o_halted;

    logic [15:0] rom [16];
    logic [11:0] exp_q [$];
    logic [11:0] got_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign i_instr = rom[o_pc];

    fde_cpu_core dut (
        .i_clk(clk), .i_reset(i_reset), .i_stop(i_stop),
`ifdef FDE_STEP_EN
        .i_step(i_step),
`endif
        .i_instr(i_instr), .o_pc(o_pc), .o_write_en(o_write_en),
        .o_write_add(o_write_add), .o_write_data(o_write_data), .o_halted(o_halted)
    );

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: advance to the falling edge and capture any write strobe.
    task automatic tick();
        @(negedge clk);
        if (o_write_en) got_q.push_back({o_write_add, o_write_data});
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic run_until_halt(input int budget);
        int n = 0;
        while (!o_halted && n < budget) begin
            tick();
            n++;
        end
        chk("halt_reached", {31'd0, o_halted}, 32'd1);
    endtask

    task automatic sb_check(input string tag);
        logic [11:0] g, e;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_write"}, {20'd0, g}, {20'd0, e});
        end
    endtask

    task automatic load_arith();
        clear_rom();
        rom[0] = enc(4'h1, 2'd0, 2'd0, 8'h05);
        rom[1] = enc(4'h1, 2'd1, 2'd0, 8'hFD);
        rom[2] = enc(4'h2, 2'd0, 2'd1, 8'h00);
        rom[3] = enc(4'h8, 2'd0, 2'd0, 8'h03);
        rom[4] = enc(4'hB, 2'd0, 2'd0, 8'h00);
    endtask

    initial begin
        // Reset state
        load_arith();
        do_reset();
        chk("rst_pc", {28'd0, o_pc}, 32'd0);
        chk("rst_we", {31'd0, o_write_en}, 32'd0);
        chk("rst_halted", {31'd0, o_halted}, 32'd0);
        chk("rst_wadd", {28'd0, o_write_add}, 32'd0);
        chk("rst_wdata", {24'd0, o_write_data}, 32'd0);

        // Arithmetic with wraparound, OUT strobe 12 cycles after release
        exp_q.push_back({4'h3, 8'h02});
        repeat (11) tick();
        chk("arith_we_early", {31'd0, o_write_en}, 32'd0);
        tick();
        chk("arith_we", {31'd0, o_write_en}, 32'd1);
        chk("arith_wadd", {28'd0, o_write_add}, 32'h3);
        chk("arith_wdata", {24'd0, o_write_data}, 32'h02);
        tick();
        chk("arith_we_pulse", {31'd0, o_write_en}, 32'd0);
        chk("arith_wdata_hold", {24'd0, o_write_data}, 32'h02);
        run_until_halt(50);
        chk("arith_halt_pc", {28'd0, o_pc}, 32'd5);
        sb_check("arith");

        // JZ taken after SUB r2,r2
        clear_rom();
        rom[0]  = enc(4'h1, 2'd2, 2'd0, 8'h01);
        rom[1]  = enc(4'h3, 2'd2, 2'd2, 8'h00);
        rom[2]  = enc(4'hA, 2'd0, 2'd0, 8'h0A);
        rom[3]  = enc(4'h8, 2'd0, 2'd2, 8'h05);
        rom[4]  = enc(4'hB, 2'd0, 2'd0, 8'h00);
        rom[10] = enc(4'h8, 2'd0, 2'd2, 8'h07);
        rom[11] = enc(4'hB, 2'd0, 2'd0, 8'h00);
        do_reset();
        exp_q.push_back({4'h7, 8'h00});
        run_until_halt(60);
        chk("jz_taken_pc", {28'd0, o_pc}, 32'hC);
        sb_check("jz_taken");

        // JZ not taken: nonzero SUB result falls through
        rom[0] = enc(4'h1, 2'd2, 2'd0, 8'h02);
        rom[1] = enc(4'h1, 2'd3, 2'd0, 8'h01);
        rom[2] = enc(4'h3, 2'd2, 2'd3, 8'h00);
        rom[3] = enc(4'hA, 2'd0, 2'd0, 8'h0A);
        rom[4] = enc(4'h8, 2'd0, 2'd2, 8'h05);
        rom[5] = enc(4'hB, 2'd0, 2'd0, 8'h00);
        do_reset();
        exp_q.push_back({4'h5, 8'h01});
        run_until_halt(60);
        chk("jz_fall_pc", {28'd0, o_pc}, 32'h6);
        sb_check("jz_fall");

        // Logic ops, MOV, Z unaffected by OUT, HALT at 0xF wraps PC to 0
        clear_rom();
        rom[0]  = enc(4'h1, 2'd0, 2'd0, 8'hC5);
        rom[1]  = enc(4'h1, 2'd1, 2'd0, 8'h3C);
        rom[2]  = enc(4'h7, 2'd2, 2'd0, 8'h00);
        rom[3]  = enc(4'h4, 2'd2, 2'd1, 8'h00);
        rom[4]  = enc(4'h8, 2'd0, 2'd2, 8'h01);
        rom[5]  = enc(4'h7, 2'd3, 2'd0, 8'h00);
        rom[6]  = enc(4'h5, 2'd3, 2'd1, 8'h00);
        rom[7]  = enc(4'h8, 2'd0, 2'd3, 8'h02);
        rom[8]  = enc(4'h6, 2'd0, 2'd1, 8'h00);
        rom[9]  = enc(4'h8, 2'd0, 2'd0, 8'h04);
        rom[10] = enc(4'h6, 2'd1, 2'd1, 8'h00);
        rom[11] = enc(4'h8, 2'd0, 2'd1, 8'h06);
        rom[12] = enc(4'hA, 2'd0, 2'd0, 8'h0E);
        rom[13] = enc(4'hB, 2'd0, 2'd0, 8'h00);
        rom[14] = enc(4'h8, 2'd0, 2'd0, 8'h09);
        rom[15] = enc(4'hB, 2'd0, 2'd0, 8'h00);
        do_reset();
        exp_q.push_back({4'h1, 8'h04});
        exp_q.push_back({4'h2, 8'hFD});
        exp_q.push_back({4'h4, 8'hF9});
        exp_q.push_back({4'h6, 8'h00});
        exp_q.push_back({4'h9, 8'hF9});
        run_until_halt(100);
        chk("logic_halt_pc", {28'd0, o_pc}, 32'h0);
        sb_check("logic");

        // NOP-equivalent opcodes fill 0..E, HALT at F; stop toggling ignored
        clear_rom();
        for (int i = 0; i < 15; i++)
            rom[i] = (i % 5 == 0) ? 16'h0000 : enc(4'hC + 4'(i % 4), 2'd1, 2'd2, 8'hFF);
        rom[15] = enc(4'hB, 2'd0, 2'd0, 8'h00);
        do_reset();
        run_until_halt(100);
        chk("wrap_pc", {28'd0, o_pc}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            i_stop = ~i_stop;
            tick();
        end
        i_stop = 1'b0;
        chk("wrap_hold_pc", {28'd0, o_pc}, 32'h0);
        chk("wrap_hold_halted", {31'd0, o_halted}, 32'd1);
        sb_check("wrap");
        do_reset();
        chk("wrap_reset_halted", {31'd0, o_halted}, 32'd0);

        // Stop raised during DECODE of OUT: strobe still issued, then hold
        load_arith();
        do_reset();
        exp_q.push_back({4'h3, 8'h02});
        repeat (10) tick();
        i_stop = 1'b1;
        tick();
        tick();
        chk("stop_we", {31'd0, o_write_en}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stop_hold_pc", {28'd0, o_pc}, 32'd4);
        end
        i_stop = 1'b0;
        run_until_halt(30);
        chk("stop_resume_pc", {28'd0, o_pc}, 32'd5);
        sb_check("stop");

        // Reset during EXECUTE of OUT aborts the write
        do_reset();
        repeat (11) tick();
        i_reset = 1'b1;
        tick();
        chk("abort_we", {31'd0, o_write_en}, 32'd0);
        chk("abort_pc", {28'd0, o_pc}, 32'd0);
        i_reset = 1'b0;
        tick();
        chk("abort_we_after", {31'd0, o_write_en}, 32'd0);
        chk("abort_pc_after", {28'd0, o_pc}, 32'd0);
        sb_check("abort");

`ifdef FDE_STEP_EN
        // Single-step: one instruction per step request, even when held
        i_stop = 1'b1;
        do_reset();
        repeat (4) tick();
        chk("step_idle_pc", {28'd0, o_pc}, 32'd0);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        repeat (8) tick();
        chk("step_one_pc", {28'd0, o_pc}, 32'd1);
        i_step = 1'b1;
        repeat (8) tick();
        i_step = 1'b0;
        chk("step_held_pc", {28'd0, o_pc}, 32'd2);
        repeat (4) tick();
        chk("step_after_pc", {28'd0, o_pc}, 32'd2);
        i_stop = 1'b0;
        sb_check("step");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
